// File: rtl/bcd_seq_calc.sv
// Sequential BCD add/subtract engine: one decimal digit per clock, signed
// 10's-complement subtraction, sign-magnitude result with carry/neg/error flags.
module bcd_seq_calc #(
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  MODE,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  output logic [4*DIGITS-1:0]   RESULT,
  output logic                  CARRY,
  output logic                  NEG,
  output logic                  ERR,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, COMP, FIN} state_t;

  state_t              state;
  state_t              state_next;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] a_reg;
  logic [4*DIGITS-1:0] b_reg;
  logic                mode_reg;
  logic                carry_reg;
  logic                last_digit;
  logic                bad_digit;
  logic [3:0]          a_dig;
  logic [3:0]          b_dig;
  logic [3:0]          r_dig;
  logic [3:0]          op_x;
  logic [3:0]          op_y;
  logic [4:0]          sum;
  logic [3:0]          dig_out;
  logic                carry_out;

  assign last_digit = (idx == IW'(DIGITS - 1));

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_reg[4*i +: 4] > 4'd9 || b_reg[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Shared digit adder: RUN adds A + (B or its 9's complement), COMP re-complements RESULT.
  always_comb begin
    a_dig = a_reg[{idx, 2'b00} +: 4];
    b_dig = b_reg[{idx, 2'b00} +: 4];
    r_dig = RESULT[{idx, 2'b00} +: 4];
    if (state == COMP) begin
      op_x = 4'd9 - r_dig;
      op_y = 4'd0;
    end else begin
      op_x = a_dig;
      op_y = mode_reg ? (4'd9 - b_dig) : b_dig;
    end
    sum = {1'b0, op_x} + {1'b0, op_y} + {4'b0000, carry_reg};
    if (sum > 5'd9) begin
      dig_out   = 4'(sum - 5'd10);
      carry_out = 1'b1;
    end else begin
      dig_out   = sum[3:0];
      carry_out = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (START) state_next = RUN;
      RUN: begin
        if (bad_digit)       state_next = FIN;
        else if (last_digit) state_next = (mode_reg && !carry_out) ? COMP : FIN;
      end
      COMP: if (last_digit) state_next = FIN;
      FIN:  state_next = START ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state == RUN) || (state == COMP);
    DONE = (state == FIN);
  end

  // No final carry in subtract mode means A < B, so the magnitude needs a second pass.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      a_reg     <= '0;
      b_reg     <= '0;
      mode_reg  <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
      RESULT    <= '0;
      CARRY     <= 1'b0;
      NEG       <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (START) begin
            a_reg     <= A;
            b_reg     <= B;
            mode_reg  <= MODE;
            carry_reg <= MODE;
            idx       <= '0;
            RESULT    <= '0;
            CARRY     <= 1'b0;
            NEG       <= 1'b0;
            ERR       <= 1'b0;
          end
        end
        RUN: begin
          if (bad_digit) begin
            ERR <= 1'b1;
          end else begin
            RESULT[{idx, 2'b00} +: 4] <= dig_out;
            if (last_digit) begin
              idx       <= '0;
              carry_reg <= 1'b1;
              if (!mode_reg) CARRY <= carry_out;
            end else begin
              idx       <= idx + 1'b1;
              carry_reg <= carry_out;
            end
          end
        end
        COMP: begin
          RESULT[{idx, 2'b00} +: 4] <= dig_out;
          carry_reg <= carry_out;
          if (last_digit) begin
            idx <= '0;
            NEG <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
